idli_io_m: RTL and testbench

IDLI_IO_M -- requirements
Module: idli_io_m

---
 rtl/idli_pkg.sv | 8 +
 rtl/idli_io_fifo_m.sv | 48 ++++
 rtl/idli_io_m.sv | 85 ++++++++
 tb/tb_idli_io_m.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli I/O block.
package idli_pkg;
    typedef logic [3:0] nibble_t;
    typedef enum logic {ST_IDLE, ST_XFER} xfer_st_t;
    localparam int WORD_NIBBLES = 4;
    localparam int RX_DEPTH_DEF = 4;
    localparam int TX_DEPTH_DEF = 4;
endpackage

// File: rtl/idli_io_fifo_m.sv
// idli_io_fifo_m: nibble FIFO of DEPTH words with occupancy count.
module idli_io_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int N = DEPTH * WORD_NIBBLES,
    localparam int CW = $clog2(N + 1),
    localparam int PW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [3:0]    i_data,
    input  logic          i_pop,
    output logic [3:0]    o_head,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    nibble_t       r_mem [N];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;

    // A pop frees the slot the same edge, so push at full is legal alongside it.
    always_comb begin
        w_pop   = i_pop & (r_cnt != '0);
        o_full  = r_cnt == CW'(N);
        w_push  = i_push & (~o_full | w_pop);
        o_head  = r_mem[r_rp];
        o_count = r_cnt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/idli_io_m.sv
// idli_io_m: word-granular RX/TX nibble buffering between the core and
// an external nibble port; a word moves only when all 4 nibbles can.
module idli_io_m
    import idli_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic       i_io_gck,
    input  logic       i_io_rst_n,
    input  logic [1:0] i_io_ctr,
    input  logic       i_io_ctr_last_cycle,
    input  logic       i_io_rd,
    output logic [3:0] o_io_rd_data,
    output logic       o_io_rd_vld,
    input  logic       i_io_wr,
    input  logic [3:0] i_io_wr_data,
    output logic       o_io_wr_rdy,
    input  logic [3:0] i_io_din,
    input  logic       i_io_din_vld,
    output logic       o_io_din_acp,
    output logic [3:0] o_io_dout,
    output logic       o_io_dout_vld,
    input  logic       i_io_dout_acp
);
    localparam int RX_N  = RX_DEPTH * WORD_NIBBLES;
    localparam int TX_N  = TX_DEPTH * WORD_NIBBLES;
    localparam int RX_CW = $clog2(RX_N + 1);
    localparam int TX_CW = $clog2(TX_N + 1);

    xfer_st_t         r_rd_st, r_wr_st;
    logic [3:0]       w_rx_head, w_tx_head;
    logic             w_rx_full, w_tx_full;
    logic [RX_CW-1:0] w_rx_count;
    logic [TX_CW-1:0] w_tx_count;
    logic             w_rd_go, w_wr_go, w_rd_act, w_wr_act;

    // Reset gates the entry decisions so every output is 0 while rst_n is low.
    always_comb begin
        w_rd_go = i_io_rst_n & (i_io_ctr == 2'd0) & i_io_rd & (r_rd_st == ST_IDLE)
                & (w_rx_count >= RX_CW'(WORD_NIBBLES));
        w_wr_go = i_io_rst_n & (i_io_ctr == 2'd0) & i_io_wr & (r_wr_st == ST_IDLE)
                & (w_tx_count <= TX_CW'(TX_N - WORD_NIBBLES));
        w_rd_act      = (r_rd_st == ST_XFER) | w_rd_go;
        w_wr_act      = (r_wr_st == ST_XFER) | w_wr_go;
        o_io_rd_vld   = w_rd_act;
        o_io_rd_data  = w_rd_act ? w_rx_head : 4'h0;
        o_io_wr_rdy   = w_wr_act;
        o_io_din_acp  = i_io_rst_n & i_io_din_vld & ~w_rx_full;
        o_io_dout_vld = w_tx_count != '0;
        o_io_dout     = o_io_dout_vld ? w_tx_head : 4'h0;
    end

    always_ff @(posedge i_io_gck or negedge i_io_rst_n) begin
        if (!i_io_rst_n) begin
            r_rd_st <= ST_IDLE;
            r_wr_st <= ST_IDLE;
        end else begin
            r_rd_st <= (w_rd_act & ~i_io_ctr_last_cycle) ? ST_XFER : ST_IDLE;
            r_wr_st <= (w_wr_act & ~i_io_ctr_last_cycle) ? ST_XFER : ST_IDLE;
        end
    end

    idli_io_fifo_m #(.DEPTH(RX_DEPTH)) u_rx (
        .i_clk   (i_io_gck),
        .i_rst_n (i_io_rst_n),
        .i_push  (o_io_din_acp),
        .i_data  (i_io_din),
        .i_pop   (w_rd_act),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_count (w_rx_count)
    );

    idli_io_fifo_m #(.DEPTH(TX_DEPTH)) u_tx (
        .i_clk   (i_io_gck),
        .i_rst_n (i_io_rst_n),
        .i_push  (w_wr_act & ~w_tx_full),
        .i_data  (i_io_wr_data),
        .i_pop   (o_io_dout_vld & i_io_dout_acp),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_count (w_tx_count)
    );
endmodule

// File: tb/tb_idli_io_m.sv
// tb_idli_io_m: directed vector table plus queue-scoreboard sequences for idli_io_m.
module tb_idli_io_m;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ctr;
    logic       rd, wr, din_vld, dout_acp;
    logic [3:0] wr_data, din;
    logic [3:0] rd_data, dout;
    logic       rd_vld, wr_rdy, din_acp, dout_vld;

    int n_vec = 0;
    int n_miss = 0;

    logic [3:0] rxq[$];
    logic [3:0] txq[$];
    logic       rd_busy = 1'b0;
    logic       wr_busy = 1'b0;
    int         rd_words, wr_words;

    typedef struct {
        logic dv; logic [3:0] dn; logic rd; logic wr; logic [3:0] wd; logic acp;
        logic e_rv; logic [3:0] e_rd; logic e_da; logic e_wy; logic e_ov; logic [3:0] e_do;
    } vec_t;
    vec_t tbl[36];

    idli_io_m dut (
        .i_io_gck            (clk),
        .i_io_rst_n          (rst_n),
        .i_io_ctr            (ctr),
        .i_io_ctr_last_cycle (ctr == 2'd3),
        .i_io_rd             (rd),
        .o_io_rd_data        (rd_data),
        .o_io_rd_vld         (rd_vld),
        .i_io_wr             (wr),
        .i_io_wr_data        (wr_data),
        .o_io_wr_rdy         (wr_rdy),
        .i_io_din            (din),
        .i_io_din_vld        (din_vld),
        .o_io_din_acp        (din_acp),
        .o_io_dout           (dout),
        .o_io_dout_vld       (dout_vld),
        .i_io_dout_acp       (dout_acp)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic vec_t mk(int dv, int dn, int r, int w, int wd, int acp,
                                int rv, int rdd, int da, int wy, int ov, int od);
        vec_t v;
        v.dv = dv[0]; v.dn = dn[3:0]; v.rd = r[0]; v.wr = w[0]; v.wd = wd[3:0]; v.acp = acp[0];
        v.e_rv = rv[0]; v.e_rd = rdd[3:0]; v.e_da = da[0]; v.e_wy = wy[0]; v.e_ov = ov[0]; v.e_do = od[3:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ctr = ctr + 2'd1;
    endtask

    task automatic drive(input logic dv, input logic [3:0] dn, input logic r, input logic w,
                         input logic [3:0] wd, input logic acp);
        din_vld = dv; din = dn; rd = r; wr = w; wr_data = wd; dout_acp = acp;
    endtask

    // One core cycle against the queue scoreboard: expectations come from queue occupancy.
    task automatic run_cyc(input logic dv, input logic [3:0] dn, input logic r, input logic w,
                           input logic [3:0] wd, input logic acp);
        logic ra, wa, ea, ov;
        drive(dv, dn, r, w, wd, acp);
        ra = rd_busy || (ctr == 2'd0 && r && rxq.size() >= 4);
        wa = wr_busy || (ctr == 2'd0 && w && txq.size() <= 12);
        ea = dv && rxq.size() < 16;
        ov = txq.size() != 0;
        #2;
        chk("rd_vld", rd_vld, ra);
        if (ra) chk("rd_data", rd_data, rxq[0]);
        chk("din_acp", din_acp, ea);
        chk("wr_rdy", wr_rdy, wa);
        chk("dout_vld", dout_vld, ov);
        if (ov) chk("dout", dout, txq[0]);
        if (ra) void'(rxq.pop_front());
        if (ov && acp) void'(txq.pop_front());
        if (ea) rxq.push_back(dn);
        if (wa) txq.push_back(wd);
        if (ctr == 2'd0 && ra) rd_words++;
        if (ctr == 2'd0 && wa) wr_words++;
        rd_busy = ra && ctr != 2'd3;
        wr_busy = wa && ctr != 2'd3;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_vld"}, rd_vld, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_din_acp"}, din_acp, 0);
        chk({tag, "_wr_rdy"}, wr_rdy, 0);
        chk({tag, "_dout_vld"}, dout_vld, 0);
        chk({tag, "_dout"}, dout, 0);
    endtask

    initial begin
        // dv dn rd wr wd acp | rv rd da wy ov do
        for (int k = 0; k < 4; k++) tbl[k]      = mk(1, k + 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) tbl[4 + k]  = mk(0, 0, 1, 0, 0, 0, 1, k + 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tbl[8 + k]  = mk(1, k + 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tbl[12 + k] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tbl[20 + k] = mk(0, 0, 1, 0, 0, 0, 1, k + 5, 0, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 1, 4'hF, 0, 0, 0, 0, 1, 0, 0);
        tbl[25] = mk(0, 0, 0, 1, 4'hE, 0, 0, 0, 0, 1, 1, 4'hF);
        tbl[26] = mk(0, 0, 0, 1, 4'hE, 0, 0, 0, 0, 1, 1, 4'hF);
        tbl[27] = mk(0, 0, 0, 1, 4'hB, 0, 0, 0, 0, 1, 1, 4'hF);
        tbl[28] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4'hF);
        tbl[29] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4'hE);
        tbl[30] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4'hE);
        tbl[31] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4'hB);
        for (int k = 0; k < 4; k++) tbl[32 + k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        ctr = 2'd0;
        drive(1, 4'h9, 1, 1, 4'h3, 1);
        #12;
        check_all_zero("reset");
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ctr = 2'd0;

        for (int i = 0; i < 36; i++) begin
            drive(tbl[i].dv, tbl[i].dn, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].acp);
            #2;
            chk($sformatf("tbl%0d_rd_vld", i), rd_vld, tbl[i].e_rv);
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_rd);
            chk($sformatf("tbl%0d_din_acp", i), din_acp, tbl[i].e_da);
            chk($sformatf("tbl%0d_wr_rdy", i), wr_rdy, tbl[i].e_wy);
            chk($sformatf("tbl%0d_dout_vld", i), dout_vld, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_do);
            tick();
        end

        // RX fill to 16, 17th rejected, then read word with din_vld at full.
        for (int k = 0; k < 16; k++) run_cyc(1, 4'(k), 0, 0, 0, 0);
        run_cyc(1, 4'hA, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) run_cyc(1, 4'(k + 3), 1, 0, 0, 0);
        while (rxq.size() >= 4) for (int k = 0; k < 4; k++) run_cyc(0, 0, 1, 0, 0, 0);

        // TX: 4 words fill it, 5th refused, then drain and see it empty.
        for (int w = 0; w < 5; w++)
            for (int k = 0; k < 4; k++) run_cyc(0, 0, 0, 1, 4'(w * 4 + k), 0);
        for (int k = 0; k < 20; k++) run_cyc(0, 0, 0, 0, 0, 1);

        rd_words = 0;
        wr_words = 0;
        for (int c = 0; c < 5000 && !(rd_words >= 100 && wr_words >= 100); c++)
            run_cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        chk("random_words_done", int'(rd_words >= 100 && wr_words >= 100), 1);

        // Reset at ctr==2 of a read, with TX also holding data.
        while (ctr != 2'd0) run_cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) run_cyc(1, 4'(k + 1), 0, 1, 4'(k + 7), 0);
        run_cyc(0, 0, 1, 0, 0, 0);
        run_cyc(0, 0, 1, 0, 0, 0);
        drive(1, 4'h5, 1, 1, 4'h5, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ctr = 2'd0;
        rxq.delete();
        txq.delete();
        rd_busy = 1'b0;
        wr_busy = 1'b0;
        for (int k = 0; k < 4; k++) run_cyc(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) run_cyc(0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
